text_renderer: RTL and testbench

Character-mode pixel pipeline between the sync `Controller` and the RGB pins. Consumes `PIXEL_CNTR`/`ROW_NUM` and raw syncs, fetches character codes from an external synchronous text RAM, then glyph rows from an external synchronous font ROM. Drives 1-bit RED/GREEN/BLUE plus syncs delayed to match the pipeline. Adds a blinking underline cursor.

---
 rtl/vga_text_pkg.sv | 11 +
 rtl/delay_line.sv | 24 ++
 rtl/text_renderer.sv | 91 +++++++++
 tb/tb_text_renderer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared text-mode geometry, pipeline latency and colour type
package vga_text_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COLS     = 80;
  localparam int ROWS     = 30;
  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int LATENCY  = 5;
  typedef logic [2:0] rgb_t;
endpackage

// File: rtl/delay_line.sv
// delay_line: DEPTH-stage register shift line, async active-low reset to RESET_VAL
//   CLK, NRST : clock, async active-low reset
//   d         : input word
//   q         : d delayed by DEPTH clocks
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe [DEPTH];
  always_ff @(posedge CLK or negedge NRST)
    if (!NRST) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/text_renderer.sv
// text_renderer: 80x30 character-cell pixel pipeline with blinking underline cursor
//   CLK, NRST                : pixel clock, async active-low reset
//   PIXEL_CNTR, ROW_NUM      : pixel coordinates from the sync controller
//   H_SYNC_IN, V_SYNC_IN     : raw active-low syncs
//   CURSOR_COL, CURSOR_ROW   : cursor cell position
//   CHAR_ADDR / CHAR_IN      : text RAM port (1-cycle read latency)
//   FONT_ADDR / FONT_DATA    : font ROM port (1-cycle read latency, bit 7 leftmost)
//   H_SYNC, V_SYNC           : syncs delayed to match the 5-clock pixel latency
//   RED, GREEN, BLUE         : registered pixel colour
module text_renderer import vga_text_pkg::*; #(
  parameter rgb_t FG_COLOR  = 3'b111,
  parameter rgb_t BG_COLOR  = 3'b000,
  parameter rgb_t CUR_COLOR = 3'b010
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [9:0]  PIXEL_CNTR,
  input  logic [9:0]  ROW_NUM,
  input  logic        H_SYNC_IN,
  input  logic        V_SYNC_IN,
  input  logic [6:0]  CURSOR_COL,
  input  logic [4:0]  CURSOR_ROW,
  output logic [11:0] CHAR_ADDR,
  input  logic [7:0]  CHAR_IN,
  output logic [11:0] FONT_ADDR,
  input  logic [7:0]  FONT_DATA,
  output logic        H_SYNC,
  output logic        V_SYNC,
  output logic        RED,
  output logic        GREEN,
  output logic        BLUE
);
  logic [6:0] col;
  logic [4:0] trow;
  logic [3:0] grow;
  logic [2:0] pix_bit;
  logic       active, cursor_hit;
  logic       s2_active, s2_hit, s4_active, s4_hit;
  logic [2:0] s2_bit, s4_bit;
  logic [3:0] s2_grow;
  logic       vs_r, vs_rr, blink_on;
  logic [4:0] blink_cnt;
  rgb_t       rgb_q, rgb_d;
  assign col        = PIXEL_CNTR[9:3];
  assign trow       = ROW_NUM[8:4];
  assign grow       = ROW_NUM[3:0];
  assign pix_bit    = PIXEL_CNTR[2:0];
  assign active     = (PIXEL_CNTR < 10'(H_ACTIVE)) && (ROW_NUM < 10'(V_ACTIVE));
  // underline occupies the bottom two glyph rows (14 and 15)
  assign cursor_hit = (col == CURSOR_COL) && (trow == CURSOR_ROW) && (grow[3:1] == 3'b111);
  assign blink_on   = ~blink_cnt[4];
  // first two stages: grow must be available when CHAR_IN returns
  delay_line #(.WIDTH(9), .DEPTH(2)) u_side_a (
    .CLK(CLK), .NRST(NRST),
    .d({active, pix_bit, grow, cursor_hit}),
    .q({s2_active, s2_bit, s2_grow, s2_hit})
  );
  // last two stages: pixel attributes aligned with FONT_DATA
  delay_line #(.WIDTH(5), .DEPTH(2)) u_side_b (
    .CLK(CLK), .NRST(NRST),
    .d({s2_active, s2_bit, s2_hit}),
    .q({s4_active, s4_bit, s4_hit})
  );
  delay_line #(.WIDTH(2), .DEPTH(LATENCY), .RESET_VAL(2'b11)) u_sync (
    .CLK(CLK), .NRST(NRST),
    .d({H_SYNC_IN, V_SYNC_IN}),
    .q({H_SYNC, V_SYNC})
  );
  always_comb
    rgb_d = !s4_active              ? 3'b000    :
            (s4_hit && blink_on)    ? CUR_COLOR :
            FONT_DATA[3'd7 - s4_bit] ? FG_COLOR  : BG_COLOR;
  always_ff @(posedge CLK or negedge NRST)
    if (!NRST) begin
      CHAR_ADDR <= '0;
      FONT_ADDR <= '0;
      rgb_q     <= '0;
      vs_r      <= 1'b1;
      vs_rr     <= 1'b1;
      blink_cnt <= '0;
    end else begin
      // trow*80 + col without a multiplier
      CHAR_ADDR <= 12'({trow, 6'b0}) + 12'({trow, 4'b0}) + 12'(col);
      FONT_ADDR <= {CHAR_IN, s2_grow};
      rgb_q     <= rgb_d;
      vs_r      <= V_SYNC_IN;
      vs_rr     <= vs_r;
      if (vs_rr && !vs_r) blink_cnt <= blink_cnt + 5'd1;
    end
  assign {RED, GREEN, BLUE} = rgb_q;
endmodule

// File: tb/tb_text_renderer.sv
// tb_text_renderer: randomized and directed checks of text_renderer against a pixel-level model
module tb_text_renderer;
  logic        CLK = 1'b0, NRST = 1'b0;
  logic [9:0]  PIXEL_CNTR = '0, ROW_NUM = '0;
  logic        H_SYNC_IN = 1'b1, V_SYNC_IN = 1'b1;
  logic [6:0]  CURSOR_COL = '0;
  logic [4:0]  CURSOR_ROW = '0;
  logic [11:0] CHAR_ADDR, FONT_ADDR;
  logic [7:0]  CHAR_IN, FONT_DATA;
  logic        H_SYNC, V_SYNC, RED, GREEN, BLUE;
  logic [7:0]  text_mem [4096];
  logic [7:0]  font_mem [4096];
  int checks = 0, errors = 0, falls = 0, prev_addr = 0, cur_c = 0, cur_r = 0;
  logic prev_vs = 1'b1;
  bit   has_prev = 0;
  typedef struct packed { logic [2:0] rgb; logic hs; logic vs; } exp_t;
  exp_t exp_q[$];

  text_renderer dut (
    .CLK(CLK), .NRST(NRST), .PIXEL_CNTR(PIXEL_CNTR), .ROW_NUM(ROW_NUM),
    .H_SYNC_IN(H_SYNC_IN), .V_SYNC_IN(V_SYNC_IN),
    .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW),
    .CHAR_ADDR(CHAR_ADDR), .CHAR_IN(CHAR_IN), .FONT_ADDR(FONT_ADDR), .FONT_DATA(FONT_DATA),
    .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .RED(RED), .GREEN(GREEN), .BLUE(BLUE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    CHAR_IN   <= text_mem[CHAR_ADDR];
    FONT_DATA <= font_mem[FONT_ADDR];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model_rgb(int x, int y, int cc, int cr, int f);
    int col, trow, grow, b;
    logic [7:0] ch, glyph;
    col = x / 8; trow = y / 16; grow = y % 16; b = x % 8;
    if (x >= 640 || y >= 480) return 3'b000;
    ch = text_mem[trow * 80 + col];
    glyph = font_mem[ch * 16 + grow];
    if (col == cc && trow == cr && grow >= 14 && (f % 32) < 16) return 3'b010;
    return glyph[7 - b] ? 3'b111 : 3'b000;
  endfunction

  task automatic step(input int x, input int y, input logic hs, input logic vs);
    exp_t e;
    @(negedge CLK);
    if (has_prev) check("char_addr", CHAR_ADDR, prev_addr);
    if (exp_q.size() == 5) begin
      e = exp_q.pop_front();
      check("rgb", {RED, GREEN, BLUE}, e.rgb);
      check("h_sync", H_SYNC, e.hs);
      check("v_sync", V_SYNC, e.vs);
    end
    PIXEL_CNTR = 10'(x); ROW_NUM = 10'(y); H_SYNC_IN = hs; V_SYNC_IN = vs;
    CURSOR_COL = 7'(cur_c); CURSOR_ROW = 5'(cur_r);
    if (prev_vs && !vs) falls++;
    prev_vs = vs;
    e.rgb = model_rgb(x, y, cur_c, cur_r, falls);
    e.hs = hs; e.vs = vs;
    exp_q.push_back(e);
    prev_addr = ((y / 16) % 32) * 80 + (x / 8) % 128;
    has_prev = 1;
  endtask

  task automatic flush();
    repeat (6) step(700, 500, 1'b1, 1'b1);
  endtask

  task automatic vsync_pulses(input int n);
    repeat (n) begin
      step(700, 500, 1'b1, 1'b0);
      step(700, 500, 1'b0, 1'b1);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rgb", {RED, GREEN, BLUE}, 3'b000);
    check("rst_h_sync", H_SYNC, 1'b1);
    check("rst_v_sync", V_SYNC, 1'b1);
    check("rst_char_addr", CHAR_ADDR, 12'd0);
    check("rst_font_addr", FONT_ADDR, 12'd0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    #2 NRST = 1'b1;
    exp_q.delete(); has_prev = 0; falls = 0; prev_vs = 1'b1;
  endtask

  task automatic directed_fill();
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'h48;
      font_mem[i] = 8'h00;
    end
    font_mem[12'h480] = 8'b1000_0001;
    font_mem[12'h48F] = 8'hFF;
  endtask

  initial begin
    directed_fill();
    repeat (2) @(posedge CLK);
    #1 check_reset_outputs();
    release_reset();
    cur_c = 5; cur_r = 2;
    for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b1);
    step(639, 479, 1'b1, 1'b1);
    step(640, 479, 1'b0, 1'b1);
    step(40, 46, 1'b1, 1'b1);
    step(40, 45, 1'b0, 1'b1);
    step(41, 47, 1'b1, 1'b1);
    flush();
    vsync_pulses(16);
    flush();
    step(40, 46, 1'b1, 1'b1);
    step(7, 15, 1'b1, 1'b1);
    flush();
    vsync_pulses(16);
    flush();
    step(40, 46, 1'b1, 1'b1);
    flush();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4096; i++) begin
        text_mem[i] = 8'($urandom);
        font_mem[i] = 8'($urandom);
      end
      cur_c = $urandom_range(0, 79); cur_r = $urandom_range(0, 29);
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 49) == 0) begin
          cur_c = $urandom_range(0, 79); cur_r = $urandom_range(0, 29);
        end
        if ($urandom_range(0, 3) == 0)
          step(cur_c * 8 + $urandom_range(0, 7), cur_r * 16 + $urandom_range(12, 15), 1'($urandom), 1'b1);
        else
          step($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'b1);
      end
      flush();
      vsync_pulses($urandom_range(1, 20));
      flush();
    end
    vsync_pulses(20);
    flush();
    for (int i = 0; i < 10; i++) step($urandom_range(0, 639), $urandom_range(0, 479), 1'b0, 1'b1);
    @(negedge CLK);
    #2 NRST = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge CLK);
    #1 check_reset_outputs();
    directed_fill();
    cur_c = 5; cur_r = 2;
    release_reset();
    step(40, 46, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1);
    step(3, 0, 1'b1, 1'b1);
    step(7, 0, 1'b0, 1'b1);
    flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
